// File: rtl/coproc_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the edge-detection
// coprocessor output stage.
package coproc_pkg;

  localparam int unsigned ROW_W         = 64;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned WORDS_PER_ROW = 2;
  localparam int unsigned SEL_W         = $clog2(WORDS_PER_ROW);

  // Row writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

  // One buffered row: data plus its precomputed RAM start address
  typedef struct packed {
    logic [ROW_W-1:0]  data;
    logic [ADDR_W-1:0] addr;
  } row_entry_t;

  localparam int unsigned ENTRY_W = $bits(row_entry_t);

  // Start address of a row: each row occupies two words, wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] calc_row_addr(input logic [ADDR_W-1:0] base,
                                                      input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] off;
    off = idx << 1;
    return base + off;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO for edge rows awaiting write-out.
// Ports:
//   clk_50M, reset   - clock, synchronous active-low reset
//   push, wr_data    - write request (ignored when full)
//   pop, rd_data     - read request (ignored when empty); rd_data shows the head
//   full, empty      - registered occupancy flags
//   count            - registered occupancy count, $clog2(DEPTH)+1 bits
module row_fifo
  import coproc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                       clk_50M,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rd_data    = mem[rd_ptr];

  // Pointers, count and flags; flags track the next count so they stay registered
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_50M) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/edge_row_writer.sv
// Writes each binary edge row into the output image RAM as two 32-bit words
// and emits a single frame_done pulse once all accepted rows are written.
// Ports:
//   clk_50M, reset            - clock, synchronous active-low reset
//   base_addr                 - image base address, sampled per row at push
//   row_valid/row_data/row_index - one-cycle row strobe with payload
//   frame_done_in             - upstream end-of-frame pulse
//   mem_wr_en/addr/data, mem_ready - stallable RAM write port
//   fifo_full, overflow       - buffer status; overflow is sticky until reset
//   rows_written              - rows completed in the current frame
//   frame_done                - one-cycle pulse when the frame is fully written
module edge_row_writer
  import coproc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              row_valid,
  input  logic [ROW_W-1:0]  row_data,
  input  logic [ADDR_W-1:0] row_index,
  input  logic              frame_done_in,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WORD_W-1:0] mem_wr_data,
  input  logic              mem_ready,
  output logic              fifo_full,
  output logic              overflow,
  output logic [ADDR_W-1:0] rows_written,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_t          state;
  row_entry_t         push_entry;
  row_entry_t         head;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_pop;
  logic               push_ok;
  logic               fifo_avail;
  logic               pending;
  logic [ROW_W-1:0]   shift_q;
  logic [SEL_W-1:0]   word_sel;

  assign push_entry = '{data: row_data, addr: calc_row_addr(base_addr, row_index)};
  assign head       = row_entry_t'(fifo_rd_data);
  assign push_ok    = row_valid && !fifo_full;
  assign fifo_pop   = (state == ST_POP) && !fifo_empty;
  // FIFO holds a row after this edge (no pop can happen in IDLE/WRITE)
  assign fifo_avail = (fifo_count != '0) || push_ok;

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_50M (clk_50M),
    .reset   (reset),
    .push    (row_valid),
    .wr_data (ENTRY_W'(push_entry)),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Write-out FSM with registered RAM port, counters and status
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      overflow     <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      rows_written <= '0;
      frame_done   <= 1'b0;
      shift_q      <= '0;
      word_sel     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (row_valid && fifo_full) overflow <= 1'b1;
      if (frame_done_in)          pending  <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (fifo_avail) begin
            state <= ST_POP;
          end else if (pending) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end

        ST_POP: begin
          shift_q     <= head.data;
          mem_wr_addr <= head.addr;
          mem_wr_data <= head.data[WORD_W-1:0];
          mem_wr_en   <= 1'b1;
          word_sel    <= '0;
          state       <= ST_WRITE;
        end

        ST_WRITE: begin
          if (mem_ready) begin
            if (word_sel == SEL_W'(WORDS_PER_ROW - 1)) begin
              mem_wr_en    <= 1'b0;
              rows_written <= rows_written + ADDR_W'(1);
              state        <= fifo_avail ? ST_POP : ST_IDLE;
            end else begin
              // Next word comes from the upper half of the shift register
              word_sel    <= word_sel + SEL_W'(1);
              shift_q     <= shift_q >> WORD_W;
              mem_wr_data <= shift_q[WORD_W +: WORD_W];
              mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
            end
          end
        end

        ST_DONE: begin
          // A fresh end-of-frame arriving now belongs to the next frame
          pending      <= frame_done_in;
          rows_written <= '0;
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_row_writer.sv
// Directed bench for edge_row_writer with a write scoreboard.
module tb_edge_row_writer;
  import coproc_pkg::*;

  logic              clk_50M = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] base_addr;
  logic              row_valid;
  logic [ROW_W-1:0]  row_data;
  logic [ADDR_W-1:0] row_index;
  logic              frame_done_in;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic              mem_ready;
  logic              fifo_full;
  logic              overflow;
  logic [ADDR_W-1:0] rows_written;
  logic              frame_done;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  n_writes = 0;
  int  wbase;

  edge_row_writer #(.FIFO_DEPTH(4)) dut (
    .clk_50M       (clk_50M),
    .reset         (reset),
    .base_addr     (base_addr),
    .row_valid     (row_valid),
    .row_data      (row_data),
    .row_index     (row_index),
    .frame_done_in (frame_done_in),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_ready     (mem_ready),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .rows_written  (rows_written),
    .frame_done    (frame_done)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard any write accepted at the coming edge, then step past it
  task automatic tick();
    wr_t e;
    @(negedge clk_50M);
    if (mem_wr_en && mem_ready) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
               mem_wr_addr, mem_wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wr_data), 64'(e.data));
      end
    end
    @(posedge clk_50M);
    #1;
  endtask

  // Drive a one-cycle row strobe; queue its two expected writes if it should be kept
  task automatic send_row(input logic [ADDR_W-1:0] idx, input logic [ROW_W-1:0] data,
                          input bit keep);
    wr_t               e;
    logic [ADDR_W-1:0] a;
    row_valid = 1'b1;
    row_index = idx;
    row_data  = data;
    if (keep) begin
      a      = ADDR_W'(32'(base_addr) + 32'(idx) * 2);
      e.addr = a;
      e.data = data[WORD_W-1:0];
      exp_q.push_back(e);
      e.addr = a + ADDR_W'(1);
      e.data = data[ROW_W-1:WORD_W];
      exp_q.push_back(e);
    end
    tick();
    row_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    reset         = 1'b0;
    base_addr     = '0;
    row_valid     = 1'b0;
    row_data      = '0;
    row_index     = '0;
    frame_done_in = 1'b0;
    mem_ready     = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 64'(mem_wr_en), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_fifo_full", 64'(fifo_full), 64'(0));
    chk("rst_rows_written", 64'(rows_written), 64'(0));
    reset = 1'b1;
    tick();

    // Single row, exact latency
    base_addr = 12'h100;
    send_row(12'd3, 64'hDEADBEEF_01234567, 1'b1);
    chk("t1_pop_en", 64'(mem_wr_en), 64'(0));
    tick();
    chk("t1_w0_en", 64'(mem_wr_en), 64'(1));
    chk("t1_w0_addr", 64'(mem_wr_addr), 64'h106);
    chk("t1_w0_data", 64'(mem_wr_data), 64'h01234567);
    tick();
    chk("t1_w1_en", 64'(mem_wr_en), 64'(1));
    chk("t1_w1_addr", 64'(mem_wr_addr), 64'h107);
    chk("t1_w1_data", 64'(mem_wr_data), 64'hDEADBEEF);
    tick();
    chk("t1_idle_en", 64'(mem_wr_en), 64'(0));
    chk("t1_rows", 64'(rows_written), 64'(1));

    // Backpressure on word 0 for 5 cycles
    do_reset();
    mem_ready = 1'b0;
    wbase = n_writes;
    send_row(12'd3, 64'hDEADBEEF_01234567, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_en", 64'(mem_wr_en), 64'(1));
      chk("t2_hold_addr", 64'(mem_wr_addr), 64'h106);
      chk("t2_hold_data", 64'(mem_wr_data), 64'h01234567);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    chk("t2_w1_addr", 64'(mem_wr_addr), 64'h107);
    tick();
    tick();
    chk("t2_nwrites", 64'(n_writes - wbase), 64'(2));
    chk("t2_rows", 64'(rows_written), 64'(1));

    // Row and end-of-frame in the same cycle
    do_reset();
    base_addr     = 12'h200;
    frame_done_in = 1'b1;
    send_row(12'd5, 64'h0F0F0F0F_A5A5A5A5, 1'b1);
    frame_done_in = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_done_early", 64'(frame_done), 64'(0));
    chk("t3_rows_pre", 64'(rows_written), 64'(1));
    tick();
    chk("t3_done_pulse", 64'(frame_done), 64'(1));
    chk("t3_rows_at_done", 64'(rows_written), 64'(1));
    tick();
    chk("t3_done_after", 64'(frame_done), 64'(0));
    chk("t3_rows_cleared", 64'(rows_written), 64'(0));
    chk("t3_queue", 64'(exp_q.size()), 64'(0));

    // Address wrap
    do_reset();
    base_addr = 12'hFFE;
    send_row(12'd0, 64'h11112222_33334444, 1'b1);
    send_row(12'd1, 64'h55556666_77778888, 1'b1);
    drain("t4_drain");
    tick();
    chk("t4_rows", 64'(rows_written), 64'(2));

    // Overflow: the first row sits stalled in the write stage, then rows 0-4
    do_reset();
    base_addr = 12'h000;
    mem_ready = 1'b0;
    wbase = n_writes;
    send_row(12'd10, 64'hB10CB10C_B10CB10C, 1'b1);
    send_row(12'd0, 64'h00000000_000000A0, 1'b1);
    send_row(12'd1, 64'h00000001_000000A1, 1'b1);
    send_row(12'd2, 64'h00000002_000000A2, 1'b1);
    chk("t5_not_full", 64'(fifo_full), 64'(0));
    send_row(12'd3, 64'h00000003_000000A3, 1'b1);
    chk("t5_full", 64'(fifo_full), 64'(1));
    chk("t5_no_ovf_yet", 64'(overflow), 64'(0));
    send_row(12'd4, 64'h00000004_000000A4, 1'b0);
    chk("t5_ovf", 64'(overflow), 64'(1));
    chk("t5_still_full", 64'(fifo_full), 64'(1));
    mem_ready = 1'b1;
    drain("t5_drain");
    for (int k = 0; k < 5; k++) tick();
    chk("t5_nwrites", 64'(n_writes - wbase), 64'(10));
    chk("t5_rows", 64'(rows_written), 64'(5));
    chk("t5_ovf_sticky", 64'(overflow), 64'(1));

    // Reset while word 0 is stalled, with an end-of-frame pending
    mem_ready     = 1'b0;
    frame_done_in = 1'b1;
    send_row(12'd7, 64'hCAFEF00D_12345678, 1'b1);
    frame_done_in = 1'b0;
    tick();
    chk("t6_writing", 64'(mem_wr_en), 64'(1));
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    chk("t6_wr_en", 64'(mem_wr_en), 64'(0));
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_full", 64'(fifo_full), 64'(0));
    chk("t6_rows", 64'(rows_written), 64'(0));
    reset     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_no_done", 64'(frame_done), 64'(0));
      chk("t6_no_write", 64'(mem_wr_en), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
